// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole controller: phase encoding and LFSR constants.
package whack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_PLAY      = 2'd2,
        ST_DONE      = 2'd3
    } game_state_e;

    // x^16 + x^14 + x^13 + x^11 + 1 : feedback from bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // One Fibonacci step: shift left, XOR of tapped bits enters at bit 0
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/whack_lfsr16.sv
// Free-running 16-bit LFSR used as the mole selection source.
module whack_lfsr16
    import whack_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    // Reseed on reset, otherwise advance every cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= LFSR_SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/whack_game_ctrl.sv
// Whack-a-mole game controller: countdown, timed play with random moles, scoring.
module whack_game_ctrl
    import whack_pkg::*;
#(
    parameter int unsigned N_MOLES        = 5,
    parameter int unsigned CYCLES_PER_SEC = 100_000_000,
    parameter int unsigned MOLE_CYCLES    = 75_000_000,
    parameter int unsigned COUNTDOWN_S    = 5,
    parameter int unsigned GAME_S         = 30,
    parameter int unsigned SCORE_W        = 8,
    parameter bit          PENALTY_EN     = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N_MOLES-1:0] button_in,
    output logic [N_MOLES-1:0] led_out,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         time_left,
    output logic [1:0]         game_state,
    output logic               game_over
);

    localparam int unsigned PRESC_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam int unsigned MOLE_W  = (MOLE_CYCLES > 1) ? $clog2(MOLE_CYCLES) : 1;
    localparam int unsigned IDX_W   = (N_MOLES > 1) ? $clog2(N_MOLES) : 1;
    localparam logic [N_MOLES-1:0] LED_ONE = N_MOLES'(1);

    game_state_e          state;
    game_state_e          state_nxt;
    logic [PRESC_W-1:0]   presc;
    logic [MOLE_W-1:0]    mole_tmr;
    logic [IDX_W-1:0]     mole_idx;
    logic [IDX_W-1:0]     mole_idx_nxt;
    logic [N_MOLES-1:0]   btn_q;
    logic [N_MOLES-1:0]   press;
    logic [N_MOLES-1:0]   led_nxt;
    logic [SCORE_W-1:0]   score_nxt;
    logic [7:0]           time_nxt;
    logic [15:0]          lfsr_q;
    logic [15:0]          raw_idx;
    logic [15:0]          alt_idx;
    logic [IDX_W-1:0]     first_idx;
    logic [IDX_W-1:0]     next_idx;
    logic                 sec_tick;
    logic                 phase_end;
    logic                 mole_due;
    logic                 hit;
    logic                 any_press;

    whack_lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    // Timing strobes, press edges and mole candidates
    always_comb begin
        sec_tick  = (presc == PRESC_W'(CYCLES_PER_SEC - 1));
        phase_end = sec_tick && (time_left == 8'd1);
        mole_due  = (mole_tmr == MOLE_W'(MOLE_CYCLES - 1));
        press     = button_in & ~btn_q;
        hit       = |(press & led_out);
        any_press = |press;
        raw_idx   = lfsr_q % 16'(N_MOLES);
        alt_idx   = (raw_idx == 16'(N_MOLES - 1)) ? 16'd0 : raw_idx + 16'd1;
        first_idx = IDX_W'(raw_idx);
        // Never repeat the previous mole back-to-back within a game
        next_idx  = (IDX_W'(raw_idx) == mole_idx) ? IDX_W'(alt_idx) : IDX_W'(raw_idx);
    end

    // Phase register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Phase transitions
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start)     state_nxt = ST_COUNTDOWN;
            ST_COUNTDOWN:     if (phase_end) state_nxt = ST_PLAY;
            ST_PLAY:          if (phase_end) state_nxt = ST_DONE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and mole index
    always_comb begin
        score_nxt    = score;
        time_nxt     = time_left;
        led_nxt      = led_out;
        mole_idx_nxt = mole_idx;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    time_nxt  = 8'(COUNTDOWN_S);
                    score_nxt = '0;
                end
            end
            ST_COUNTDOWN: begin
                if (phase_end) begin
                    time_nxt     = 8'(GAME_S);
                    mole_idx_nxt = first_idx;
                    led_nxt      = LED_ONE << first_idx;
                end else if (sec_tick) begin
                    time_nxt = time_left - 8'd1;
                end
            end
            ST_PLAY: begin
                // At most one score change per cycle; a match wins over misses
                if (hit) begin
                    if (score != '1) score_nxt = score + SCORE_W'(1);
                end else if (any_press && PENALTY_EN) begin
                    if (score != '0) score_nxt = score - SCORE_W'(1);
                end
                if (phase_end) begin
                    time_nxt = 8'd0;
                    led_nxt  = '0;
                end else begin
                    if (sec_tick) time_nxt = time_left - 8'd1;
                    // Presses are judged against the old LED; the new mole still shows
                    if (mole_due) begin
                        mole_idx_nxt = next_idx;
                        led_nxt      = LED_ONE << next_idx;
                    end else if (hit) begin
                        led_nxt = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers: prescaler, mole timer, button history, outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc     <= '0;
            mole_tmr  <= '0;
            btn_q     <= '0;
            mole_idx  <= '0;
            led_out   <= '0;
            score     <= '0;
            time_left <= 8'd0;
            game_over <= 1'b0;
        end else begin
            presc     <= ((state_nxt != state) || sec_tick) ? '0 : presc + PRESC_W'(1);
            mole_tmr  <= ((state == ST_PLAY) && (state_nxt == ST_PLAY) && !mole_due)
                         ? mole_tmr + MOLE_W'(1) : '0;
            btn_q     <= button_in;
            mole_idx  <= mole_idx_nxt;
            led_out   <= led_nxt;
            score     <= score_nxt;
            time_left <= time_nxt;
            game_over <= (state_nxt == ST_DONE);
        end
    end

    assign game_state = state;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Directed bench for whack_game_ctrl with a penalty and a no-penalty instance sharing stimulus.
module tb_whack_game_ctrl;

    localparam int N = 5;

    logic         clk;
    logic         reset;
    logic         start;
    logic [N-1:0] button_in;
    logic [N-1:0] led_out;
    logic [7:0]   score;
    logic [7:0]   time_left;
    logic [1:0]   game_state;
    logic         game_over;
    logic [N-1:0] np_led;
    logic [7:0]   np_score;
    logic [7:0]   np_time;
    logic [1:0]   np_state;
    logic         np_over;

    int tests;
    int fails;
    int t;
    int exp_idx;
    int old_idx;
    int exp_s1;
    int exp_s0;
    bit track;
    bit rec;
    int first_moles [8];
    logic [N-1:0] exp_led;
    logic [15:0]  m_q;
    logic [15:0]  m_q_used;

    whack_game_ctrl #(
        .N_MOLES(N), .CYCLES_PER_SEC(10), .MOLE_CYCLES(4), .COUNTDOWN_S(2),
        .GAME_S(3), .SCORE_W(8), .PENALTY_EN(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .button_in(button_in),
        .led_out(led_out), .score(score), .time_left(time_left),
        .game_state(game_state), .game_over(game_over)
    );

    whack_game_ctrl #(
        .N_MOLES(N), .CYCLES_PER_SEC(10), .MOLE_CYCLES(4), .COUNTDOWN_S(2),
        .GAME_S(3), .SCORE_W(8), .PENALTY_EN(1'b0)
    ) dut_np (
        .clk(clk), .reset(reset), .start(start), .button_in(button_in),
        .led_out(np_led), .score(np_score), .time_left(np_time),
        .game_state(np_state), .game_over(np_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR; m_q_used is the value the design saw at the latest edge
    always_ff @(posedge clk) begin
        m_q_used <= m_q;
        if (!reset) m_q <= 16'hACE1;
        else        m_q <= {m_q[14:0], m_q[15] ^ m_q[13] ^ m_q[12] ^ m_q[10]};
    end

    function automatic int pick(input logic [15:0] q, input int prev, input bit first);
        int r;
        r = int'(q % 16'(N));
        if (!first && r == prev) r = (r + 1) % N;
        return r;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = N'(1);
        return v << i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock, sample 1 ns later; follows the mole schedule while tracking a game
    task automatic adv();
        @(posedge clk);
        #1;
        if (track) begin
            t++;
            if ((t % 4 == 0) && (t < 30)) begin
                exp_idx = pick(m_q_used, exp_idx, 1'b0);
                exp_led = oh(exp_idx);
                if (rec) first_moles[t / 4] = exp_idx;
            end
        end
    endtask

    initial begin
        tests = 0; fails = 0; t = 0; exp_idx = 0; old_idx = 0;
        exp_s1 = 0; exp_s0 = 0; track = 1'b0; rec = 1'b0; exp_led = '0;
        foreach (first_moles[i]) first_moles[i] = 0;
        reset = 1'b0; start = 1'b0; button_in = '0;

        adv(); adv();
        chk("rst_state", 32'(game_state), 32'd0);
        chk("rst_led",   32'(led_out),    32'd0);
        chk("rst_score", 32'(score),      32'd0);
        chk("rst_time",  32'(time_left),  32'd0);
        chk("rst_over",  32'(game_over),  32'd0);

        reset = 1'b1;
        adv(); adv();
        chk("idle_hold", 32'(game_state), 32'd0);

        start = 1'b1;
        adv();
        chk("cd_state", 32'(game_state), 32'd1);
        chk("cd_time",  32'(time_left),  32'd2);
        adv(); adv();
        start = 1'b0;
        chk("cd_start_ignored", 32'(game_state), 32'd1);
        repeat (7) adv();
        chk("cd_time_pre_tick", 32'(time_left), 32'd2);
        adv();
        chk("cd_time_tick", 32'(time_left), 32'd1);
        repeat (9) adv();
        chk("cd_not_yet_play", 32'(game_state), 32'd1);
        adv();

        // PLAY entry: first mole straight from the LFSR
        exp_idx = pick(m_q_used, 0, 1'b1);
        exp_led = oh(exp_idx);
        first_moles[0] = exp_idx;
        t = 0; track = 1'b1; rec = 1'b1;
        chk("play_state", 32'(game_state), 32'd2);
        chk("play_time",  32'(time_left),  32'd3);
        chk("play_led",   32'(led_out),    32'(exp_led));

        button_in = oh(exp_idx); adv();
        exp_s1 = 1; exp_s0 = 1; exp_led = '0;
        chk("hit_score",    32'(score),    32'(exp_s1));
        chk("hit_score_np", 32'(np_score), 32'(exp_s0));
        chk("hit_led_off",  32'(led_out),  32'(exp_led));

        button_in = '0; adv();
        button_in = oh(exp_idx); adv();
        exp_s1 = 0;
        chk("rehit_penalty", 32'(score),    32'(exp_s1));
        chk("rehit_np",      32'(np_score), 32'(exp_s0));
        chk("rehit_led_off", 32'(led_out),  32'd0);

        button_in = '0; adv();
        chk("load1_led", 32'(led_out), 32'(exp_led));

        button_in = oh((exp_idx + 1) % N); adv();
        chk("wrong_floor", 32'(score),    32'd0);
        chk("wrong_np",    32'(np_score), 32'(exp_s0));

        button_in = '0; adv();
        button_in = oh(exp_idx) | oh((exp_idx + 2) % N); adv();
        exp_s1 = 1; exp_s0 = 2; exp_led = '0;
        chk("multi_score",    32'(score),    32'(exp_s1));
        chk("multi_score_np", 32'(np_score), 32'(exp_s0));
        chk("multi_led_off",  32'(led_out),  32'(exp_led));

        button_in = '0; adv();
        chk("load2_led", 32'(led_out), 32'(exp_led));
        adv(); adv();
        chk("play_time_tick", 32'(time_left), 32'd2);
        adv();

        // Press lands on the load edge: scored against the old mole, new mole shows
        old_idx = exp_idx;
        button_in = oh(old_idx); adv();
        exp_s1 = 2; exp_s0 = 3;
        chk("loadhit_score",    32'(score),    32'(exp_s1));
        chk("loadhit_score_np", 32'(np_score), 32'(exp_s0));
        chk("loadhit_led_new",  32'(led_out),  32'(exp_led));

        button_in = '0; adv();
        button_in = oh((exp_idx + 1) % N); adv();
        exp_s1 = 1;
        chk("wrong3_score",    32'(score),    32'(exp_s1));
        chk("wrong3_np_holds", 32'(np_score), 32'd3);

        button_in = '0;
        while (t < 29) adv();
        chk("late_state", 32'(game_state), 32'd2);
        chk("late_time",  32'(time_left),  32'd1);
        chk("late_led",   32'(led_out),    32'(exp_led));

        // Hit on the final PLAY cycle is credited before DONE
        button_in = oh(exp_idx); adv();
        exp_s1 = 2; exp_s0 = 4;
        chk("done_state",    32'(game_state), 32'd3);
        chk("done_over",     32'(game_over),  32'd1);
        chk("done_led",      32'(led_out),    32'd0);
        chk("done_time",     32'(time_left),  32'd0);
        chk("done_score",    32'(score),      32'(exp_s1));
        chk("done_score_np", 32'(np_score),   32'(exp_s0));
        chk("done_np_state", 32'(np_state),   32'd3);
        chk("done_np_over",  32'(np_over),    32'd1);
        chk("done_np_led",   32'(np_led),     32'd0);
        chk("done_np_time",  32'(np_time),    32'd0);

        button_in = '0; track = 1'b0; rec = 1'b0;
        adv(); adv();
        chk("done_hold_state", 32'(game_state), 32'd3);
        chk("done_hold_score", 32'(score),      32'(exp_s1));

        start = 1'b1; adv(); start = 1'b0;
        chk("restart_state",    32'(game_state), 32'd1);
        chk("restart_score",    32'(score),      32'd0);
        chk("restart_score_np", 32'(np_score),   32'd0);
        chk("restart_time",     32'(time_left),  32'd2);
        chk("restart_over",     32'(game_over),  32'd0);
        repeat (20) adv();
        chk("restart_play", 32'(game_state), 32'd2);
        repeat (5) adv();

        reset = 1'b0; adv(); reset = 1'b1;
        chk("midrst_state", 32'(game_state), 32'd0);
        chk("midrst_led",   32'(led_out),    32'd0);
        chk("midrst_score", 32'(score),      32'd0);
        chk("midrst_time",  32'(time_left),  32'd0);
        chk("midrst_over",  32'(game_over),  32'd0);

        // Same edge count from reset as the first game, so the same moles
        adv(); adv();
        start = 1'b1; adv(); start = 1'b0;
        repeat (20) adv();
        chk("rep_state", 32'(game_state), 32'd2);
        chk("rep_mole0", 32'(led_out), 32'(oh(first_moles[0])));
        repeat (4) adv();
        chk("rep_mole1", 32'(led_out), 32'(oh(first_moles[1])));
        repeat (4) adv();
        chk("rep_mole2", 32'(led_out), 32'(oh(first_moles[2])));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
